npc_btb: RTL and testbench

//  Next-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.

---
 rtl/npc_btb.sv | 154 +++++++++++++++
 tb/tb_npc_btb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_btb.sv
// Next-PC generator for the fetch head: PC register plus a direct-mapped
// BTB with 2-bit direction counters, trained by the backend.
module npc_btb #(
    parameter logic [31:0] RESET_PC    = 32'h1c00_0000,
    parameter int          BTB_ENTRIES = 64,
    parameter int          TAG_W       = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_target_i,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    output logic [31:0] pc_o,
    output logic        pred_taken_o,
    output logic [29:0] pred_npc_o,
    output logic        pred_fsc_o,
    output logic        stall_o
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_LO = IDX_W + 3;
    localparam int TAG_HI = TAG_W + IDX_W + 2;

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;

    logic             valid_q [BTB_ENTRIES];
    logic             valid_d [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_d   [BTB_ENTRIES];
    logic             slot_q  [BTB_ENTRIES];
    logic             slot_d  [BTB_ENTRIES];
    logic [29:0]      tgt_q   [BTB_ENTRIES];
    logic [29:0]      tgt_d   [BTB_ENTRIES];
    logic [1:0]       ctr_q   [BTB_ENTRIES];
    logic [1:0]       ctr_d   [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [28:0]      seq_hi;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_slot;
    logic             up_match;

    logic             unused_bits;

    assign lk_idx  = pc_q[IDX_W+2:3];
    assign lk_tag  = pc_q[TAG_HI:TAG_LO];
    assign seq_hi  = pc_q[31:3] + 29'd1;

    assign up_idx  = upd_pc_i[IDX_W+2:3];
    assign up_tag  = upd_pc_i[TAG_HI:TAG_LO];
    assign up_slot = upd_pc_i[2];

    assign pc_o    = pc_q;
    assign stall_o = 1'b0;

    assign unused_bits = ^{upd_pc_i[31:TAG_HI+1], upd_pc_i[1:0],
                           upd_target_i[1:0]};

    // Lookup: a slot-0 branch is invisible when fetch enters at slot 1
    always_comb begin
        lk_hit = valid_q[lk_idx]
               && (tag_q[lk_idx] == lk_tag)
               && (slot_q[lk_idx] >= pc_q[2]);
    end

    // Prediction: taken hit redirects, otherwise next sequential packet
    always_comb begin
        pred_taken_o = lk_hit & ctr_q[lk_idx][1];
        pred_npc_o   = {seq_hi, 1'b0};
        pred_fsc_o   = 1'b1;
        if (pred_taken_o) begin
            pred_npc_o = tgt_q[lk_idx];
            pred_fsc_o = slot_q[lk_idx];
        end
    end

    // Next fetch PC: flush beats stall beats advance
    always_comb begin
        pc_d = {pred_npc_o, 2'b00};
        if (flush_i) begin
            pc_d = flush_target_i;
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    // Training: bump/decay a matching entry, allocate on a taken miss
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        slot_d   = slot_q;
        tgt_d    = tgt_q;
        ctr_d    = ctr_q;
        up_match = valid_q[up_idx]
                 && (tag_q[up_idx] == up_tag)
                 && (slot_q[up_idx] == up_slot);
        if (upd_valid_i) begin
            if (up_match) begin
                if (upd_taken_i) begin
                    if (ctr_q[up_idx] != 2'b11) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
                    end
                    tgt_d[up_idx] = upd_target_i[31:2];
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
                end
            end else if (upd_taken_i) begin
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                slot_d[up_idx]  = up_slot;
                tgt_d[up_idx]   = upd_target_i[31:2];
                ctr_d[up_idx]   = 2'b10;
            end
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // BTB storage; reset wipes every entry so nothing half-written survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                slot_q[i]  <= 1'b0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b00;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            slot_q  <= slot_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
        end
    end

endmodule

// File: tb/tb_npc_btb.sv
// Bench for npc_btb: directed scenarios then random traffic, checked by
// a scoreboard against a behavioural model of the fetch/BTB rules.
module tb_npc_btb;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
    localparam int ENT  = 64;
    localparam int IDXW = 6;
    localparam int TAGW = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_target_i = '0;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic [31:0] upd_target_i = '0;
    logic [31:0] pc_o;
    logic        pred_taken_o;
    logic [29:0] pred_npc_o;
    logic        pred_fsc_o;
    logic        stall_o;

    npc_btb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .flush_target_i (flush_target_i),
        .upd_valid_i    (upd_valid_i),
        .upd_pc_i       (upd_pc_i),
        .upd_taken_i    (upd_taken_i),
        .upd_target_i   (upd_target_i),
        .pc_o           (pc_o),
        .pred_taken_o   (pred_taken_o),
        .pred_npc_o     (pred_npc_o),
        .pred_fsc_o     (pred_fsc_o),
        .stall_o        (stall_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [31:0] pc;
        bit        tk;
        bit [29:0] npc;
        bit        fsc;
    } exp_t;

    typedef struct {
        bit        v;
        bit [31:0] bpc;
        bit [31:0] tgt;
        int        ctr;
    } ment_t;

    exp_t      q[$];
    ment_t     mb[ENT];
    bit [31:0] mpc;
    int        checks = 0;
    int        errors = 0;

    bit [31:0] pool[12] = '{
        32'h1c00_0000, 32'h1c00_0004, 32'h1c00_0010, 32'h1c00_0014,
        32'h1c00_0200, 32'h1c00_0204, 32'h1c00_0100, 32'h1c00_0104,
        32'h1c00_0400, 32'h1c00_0018, 32'hffff_fff8, 32'hffff_fffc
    };

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int unsigned f_idx(bit [31:0] a);
        return (a >> 3) % ENT;
    endfunction

    function automatic int unsigned f_tag(bit [31:0] a);
        return (a >> (3 + IDXW)) % (1 << TAGW);
    endfunction

    function automatic exp_t predict(bit [31:0] pc);
        ment_t     e;
        exp_t      r;
        bit        hit;
        bit [31:0] seq;
        e   = mb[f_idx(pc)];
        hit = e.v && (f_tag(e.bpc) == f_tag(pc)) && (e.bpc[2] >= pc[2]);
        seq = ((pc >> 3) + 1) << 3;
        r.pc = pc;
        r.tk = hit && (e.ctr >= 2);
        if (r.tk) begin
            r.npc = e.tgt[31:2];
            r.fsc = e.bpc[2];
        end else begin
            r.npc = seq[31:2];
            r.fsc = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) mb[i].v = 1'b0;
        mpc = RST_PC;
    endtask

    task automatic model_step(input bit st, input bit fl, input bit [31:0] ft,
                              input bit uv, input bit [31:0] up,
                              input bit ut, input bit [31:0] utg);
        exp_t        p;
        int unsigned i;
        bit          m;
        p = predict(mpc);
        if (fl) mpc = ft;
        else if (!st) mpc = {p.npc, 2'b00};
        if (uv) begin
            i = f_idx(up);
            m = mb[i].v && (f_tag(mb[i].bpc) == f_tag(up))
                && (mb[i].bpc[2] == up[2]);
            if (m && ut) begin
                mb[i].ctr = (mb[i].ctr < 3) ? mb[i].ctr + 1 : 3;
                mb[i].tgt = utg;
            end else if (m) begin
                mb[i].ctr = (mb[i].ctr > 0) ? mb[i].ctr - 1 : 0;
            end else if (ut) begin
                mb[i].v   = 1'b1;
                mb[i].bpc = up;
                mb[i].tgt = utg;
                mb[i].ctr = 2;
            end
        end
    endtask

    // Called at posedge+1: expect current outputs, drive a cycle, advance
    task automatic apply(input bit st, input bit fl, input bit [31:0] ft,
                         input bit uv, input bit [31:0] up,
                         input bit ut, input bit [31:0] utg);
        q.push_back(predict(mpc));
        stall_i        = st;
        flush_i        = fl;
        flush_target_i = ft;
        upd_valid_i    = uv;
        upd_pc_i       = up;
        upd_taken_i    = ut;
        upd_target_i   = utg;
        model_step(st, fl, ft, uv, up, ut, utg);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redirect(input bit [31:0] a);
        apply(0, 1, a, 0, 0, 0, 0);
    endtask

    task automatic train(input bit [31:0] a, input bit t, input bit [31:0] g);
        apply(0, 0, 0, 1, a, t, g);
    endtask

    // Mid-cycle async reset with a taken update pending on the bus
    task automatic do_reset();
        #2;
        rst_n        = 1'b0;
        stall_i      = 1'b0;
        flush_i      = 1'b0;
        upd_valid_i  = 1'b1;
        upd_pc_i     = 32'h1c00_0000;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'h1c00_0040;
        model_reset();
        #1;
        q.push_back(predict(mpc));
        @(posedge clk);
        #1;
        upd_valid_i = 1'b0;
        rst_n       = 1'b1;
    endtask

    // Monitor: compare DUT outputs against queued expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_o", pc_o, e.pc);
                chk("pred_taken_o", {31'd0, pred_taken_o}, {31'd0, e.tk});
                chk("pred_npc_o", {2'd0, pred_npc_o}, {2'd0, e.npc});
                chk("pred_fsc_o", {31'd0, pred_fsc_o}, {31'd0, e.fsc});
                chk("stall_o", {31'd0, stall_o}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_pc", pc_o, 32'h1c00_0000);

        // sequential fetch from reset
        repeat (3) idle();

        // stall hold, then flush beating stall
        redirect(32'h1c00_0008);
        repeat (3) apply(1, 0, 0, 0, 0, 0, 0);
        idle();
        apply(1, 1, 32'h1c00_0104, 0, 0, 0, 0);
        idle();
        chk("flush_then_seq", pc_o, 32'h1c00_0108);

        // train a slot-1 branch, then fetch its packet
        apply(0, 1, 32'h1c00_0000, 1, 32'h1c00_0004, 1, 32'h1c00_0100);
        chk("t3_taken", {31'd0, pred_taken_o}, 32'd1);
        chk("t3_npc", {2'd0, pred_npc_o}, 32'h0700_0040);
        idle();
        chk("t3_next_pc", pc_o, 32'h1c00_0100);
        redirect(32'h1c00_0004);
        idle();

        // counter walk down, then up to saturation
        train(32'h1c00_0004, 0, 0);
        train(32'h1c00_0004, 0, 0);
        redirect(32'h1c00_0000);
        chk("t4_not_taken", {31'd0, pred_taken_o}, 32'd0);
        chk("t4_npc", {2'd0, pred_npc_o}, 32'h0700_0002);
        repeat (3) train(32'h1c00_0004, 1, 32'h1c00_0100);
        redirect(32'h1c00_0000);
        idle();

        // slot filter
        train(32'h1c00_0000, 1, 32'h1c00_0300);
        redirect(32'h1c00_0004);
        chk("t5_filtered", {31'd0, pred_taken_o}, 32'd0);
        chk("t5_npc", {2'd0, pred_npc_o}, 32'h0700_0002);

        // alias eviction, then same-cycle lookup/update hazard
        train(32'h1c00_0200, 1, 32'h1c00_0400);
        redirect(32'h1c00_0000);
        chk("t6_evicted", {31'd0, pred_taken_o}, 32'd0);
        apply(1, 0, 0, 1, 32'h1c00_0000, 1, 32'h1c00_0500);
        chk("t6_new_taken", {31'd0, pred_taken_o}, 32'd1);
        chk("t6_new_npc", {2'd0, pred_npc_o}, 32'h0700_0140);
        idle();

        // packet address wrap
        redirect(32'hffff_fffc);
        chk("wrap_npc", {2'd0, pred_npc_o}, 32'd0);
        idle();
        chk("wrap_pc", pc_o, 32'd0);

        // reset in the middle of operation
        train(32'h1c00_0004, 1, 32'h1c00_0100);
        do_reset();
        redirect(32'h1c00_0000);
        chk("reset_cleared", {31'd0, pred_taken_o}, 32'd0);
        idle();

        // random traffic
        for (int n = 0; n < 800; n++) begin
            apply(($urandom % 4) == 0, ($urandom % 5) == 0,
                  pool[$urandom % 12], $urandom % 2, pool[$urandom % 12],
                  ($urandom % 3) != 0, pool[$urandom % 12]);
            if (n == 400) do_reset();
        end
        idle();

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
